// File: rtl/mips_memory.sv
// Unified instruction/data memory for the multicycle MIPS core, with a
// valid/ready program-load stream and a two-register memory-mapped I/O window.
module mips_memory #(
  parameter int              WIDTH   = 32,
  parameter int              DEPTH   = 256,
  parameter logic [WIDTH-1:0] IO_ADDR = 32'hFFFF_FFF0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_run,
  output logic             misalign,
  output logic [WIDTH-1:0] io_out
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] CNT_ADDR = IO_ADDR + WIDTH'(4);

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ld_ptr_q, ld_ptr_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic [WIDTH-1:0] io_q, io_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic [AW-1:0]    idx;
  logic             in_range, hit_io, hit_cnt, aligned;

  assign idx      = addr[AW+1:2];
  assign in_range = (addr >> (AW + 2)) == '0;
  assign hit_io   = addr == IO_ADDR;
  assign hit_cnt  = addr == CNT_ADDR;
  assign aligned  = addr[1:0] == 2'b00;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ld_ptr_d    = ld_ptr_q;
    read_data_d = read_data_q;
    io_d        = io_q;
    cnt_d       = cnt_q;
    misalign_d  = misalign_q;
    mem_we      = 1'b0;
    mem_waddr   = ld_ptr_q;
    mem_wdata   = ld_data;
    ld_ready    = 1'b0;
    cpu_run     = 1'b0;

    case (state_q)
      S_LOAD: begin
        ld_ready    = 1'b1;
        read_data_d = '0;
        if (ld_valid) begin
          mem_we   = 1'b1;
          ld_ptr_d = ld_ptr_q + AW'(1);
          if (ld_last || ld_ptr_q == AW'(DEPTH - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
      end

      S_RUN: begin
        cpu_run = 1'b1;
        cnt_d   = cnt_q + WIDTH'(1);
        // Read-first: the registered read sees the array before this edge's write.
        if (in_range)     read_data_d = mem[idx];
        else if (hit_io)  read_data_d = io_q;
        else if (hit_cnt) read_data_d = cnt_q;
        else              read_data_d = '0;

        if (!aligned) begin
          misalign_d = 1'b1;
        end else if (mem_write) begin
          if (in_range) begin
            mem_we    = 1'b1;
            mem_waddr = idx;
            mem_wdata = write_data;
          end else if (hit_io) begin
            io_d = write_data;
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      ld_ptr_q    <= '0;
      read_data_q <= '0;
      io_q        <= '0;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      read_data_q <= read_data_d;
      io_q        <= io_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  // NOTE: the array is deliberately left out of reset; contents survive a
  // reset and a fresh load simply overwrites them.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign read_data = read_data_q;
  assign io_out    = io_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mips_memory.sv
// Self-checking bench for mips_memory: directed program scenarios plus
// randomized RUN traffic scored against a word-array reference model.
module tb_mips_memory;

  localparam logic [31:0] IO  = 32'hFFFF_FFF0;
  localparam logic [31:0] CNT = 32'hFFFF_FFF4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with default DEPTH = 256
  logic        reset, mem_write, ld_valid, ld_last, ld_ready, cpu_run, misalign;
  logic [31:0] addr, write_data, read_data, ld_data, io_out;

  // DUT with DEPTH = 4 for stream truncation
  logic        reset4, mem_write4, ld_valid4, ld_last4, ld_ready4, cpu_run4, misalign4;
  logic [31:0] addr4, write_data4, read_data4, ld_data4, io_out4;

  mips_memory dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(read_data), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_run(cpu_run), .misalign(misalign), .io_out(io_out)
  );

  mips_memory #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset4), .mem_write(mem_write4), .addr(addr4),
    .write_data(write_data4), .read_data(read_data4), .ld_valid(ld_valid4),
    .ld_data(ld_data4), .ld_last(ld_last4), .ld_ready(ld_ready4),
    .cpu_run(cpu_run4), .misalign(misalign4), .io_out(io_out4)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model of the 256-word DUT
  logic [31:0] mem_m [256];
  bit          known [256];
  int          ptr_m;
  bit          run_m, mis_m;
  logic [31:0] io_m, cnt_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_write = 1'b0; addr = '0; write_data = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ptr_m = 0; run_m = 1'b0; mis_m = 1'b0; io_m = '0; cnt_m = '0;
    checks++; if (cpu_run !== 1'b0)   begin failures++; $display("FAIL reset_cpu_run: got %b want 0", cpu_run); end
    checks++; if (ld_ready !== 1'b1)  begin failures++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    checks++; if (read_data !== '0)   begin failures++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    checks++; if (io_out !== '0)      begin failures++; $display("FAIL reset_io_out: got %h want 0", io_out); end
    checks++; if (misalign !== 1'b0)  begin failures++; $display("FAIL reset_misalign: got %b want 0", misalign); end
  endtask

  // One LOAD-state cycle; the core bus is driven with writes that must be ignored.
  task automatic load_cycle(input bit v, input logic [31:0] d, input bit last);
    ld_valid = v; ld_data = d; ld_last = last;
    mem_write = 1'b1; addr = d[0] ? IO : 32'h0000_0005; write_data = ~d;
    checks++; if (ld_ready !== !run_m) begin failures++; $display("FAIL ld_ready: got %b want %b", ld_ready, !run_m); end
    step();
    if (v && !run_m) begin
      mem_m[ptr_m] = d; known[ptr_m] = 1'b1;
      if (last || ptr_m == 255) begin run_m = 1'b1; cnt_m = '0; end
      ptr_m++;
    end
    idle_inputs();
    checks++; if (cpu_run !== run_m)  begin failures++; $display("FAIL load_cpu_run: got %b want %b", cpu_run, run_m); end
    checks++; if (read_data !== '0)   begin failures++; $display("FAIL load_read_data: got %h want 0", read_data); end
    checks++; if (io_out !== io_m)    begin failures++; $display("FAIL load_io_out: got %h want %h", io_out, io_m); end
    checks++; if (misalign !== mis_m) begin failures++; $display("FAIL load_misalign: got %b want %b", misalign, mis_m); end
  endtask

  // One RUN-state core access scored against the model; optional junk on the load stream.
  task automatic run_cycle(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input bit junk, output logic [31:0] got);
    logic [31:0] exp;
    bit          chk;
    chk = 1'b1;
    if (a < 32'd1024) begin
      chk = known[a[9:2]];
      exp = mem_m[a[9:2]];
    end else if (a == IO)  exp = io_m;
    else if (a == CNT)     exp = cnt_m;
    else                   exp = '0;

    mem_write = we; addr = a; write_data = wd;
    ld_valid = junk; ld_data = $urandom; ld_last = junk;
    checks++; if ({cpu_run, ld_ready} !== 2'b10) begin failures++; $display("FAIL run_status: got %b want 10", {cpu_run, ld_ready}); end
    step();
    if (a[1:0] != 2'b00) mis_m = 1'b1;
    else if (we) begin
      if (a < 32'd1024) begin mem_m[a[9:2]] = wd; known[a[9:2]] = 1'b1; end
      else if (a == IO) io_m = wd;
    end
    cnt_m = cnt_m + 1;
    idle_inputs();
    got = read_data;
    if (chk) begin
      checks++; if (read_data !== exp) begin failures++; $display("FAIL run_read addr=%h: got %h want %h", a, read_data, exp); end
    end
    checks++; if (io_out !== io_m)    begin failures++; $display("FAIL run_io_out: got %h want %h", io_out, io_m); end
    checks++; if (misalign !== mis_m) begin failures++; $display("FAIL run_misalign: got %b want %b", misalign, mis_m); end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_program();
    logic [31:0] prog [4];
    logic [31:0] got;
    prog = '{32'h2008_0005, 32'h2009_000A, 32'h0109_5020, 32'hAC0A_0040};
    do_reset();
    for (int i = 0; i < 4; i++) load_cycle(1'b1, prog[i], i == 3);
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL prog_run_entered: got %b want 1", cpu_run); end
    for (int i = 0; i < 4; i++) begin                                              // run cycles 1..4
      run_cycle(1'b0, 32'(i * 4), '0, 1'b0, got);
      checks++; if (got !== prog[i]) begin failures++; $display("FAIL prog_word%0d: got %h want %h", i, got, prog[i]); end
    end
    run_cycle(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, got);                             // 5
    run_cycle(1'b0, 32'h40, '0, 1'b0, got);                                        // 6
    checks++; if (got !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rd_40: got %h want deadbeef", got); end
    run_cycle(1'b1, 32'h44, 32'h1111_1111, 1'b0, got);                             // 7
    run_cycle(1'b1, 32'h44, 32'hCAFE_F00D, 1'b0, got);                             // 8
    checks++; if (got !== 32'h1111_1111) begin failures++; $display("FAIL read_first_old: got %h want 11111111", got); end
    run_cycle(1'b0, 32'h44, '0, 1'b0, got);                                        // 9
    checks++; if (got !== 32'hCAFE_F00D) begin failures++; $display("FAIL read_first_new: got %h want cafef00d", got); end
    run_cycle(1'b0, CNT, '0, 1'b0, got);                                           // 10
    checks++; if (got !== 32'd9) begin failures++; $display("FAIL cycle_count: got %0d want 9", got); end
    run_cycle(1'b1, IO, 32'h1234_5678, 1'b0, got);
    checks++; if (io_out !== 32'h1234_5678) begin failures++; $display("FAIL io_write: got %h want 12345678", io_out); end
    run_cycle(1'b0, IO, '0, 1'b0, got);
    checks++; if (got !== 32'h1234_5678) begin failures++; $display("FAIL io_read: got %h want 12345678", got); end
    run_cycle(1'b1, 32'h41, 32'hBAD0_BAD0, 1'b0, got);
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_set: got %b want 1", misalign); end
    run_cycle(1'b0, 32'h42, '0, 1'b0, got);
    checks++; if (got !== 32'hDEAD_BEEF) begin failures++; $display("FAIL misalign_read: got %h want deadbeef", got); end
    run_cycle(1'b0, 32'h40, '0, 1'b0, got);
    checks++; if (got !== 32'hDEAD_BEEF) begin failures++; $display("FAIL misalign_no_write: got %h want deadbeef", got); end
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_sticky: got %b want 1", misalign); end
  endtask

  task automatic test_random();
    logic [31:0] a, got;
    int n;
    do_reset();
    n = 0;
    while (n < 256) begin
      bit v;
      v = $urandom_range(0, 3) != 0;
      load_cycle(v, $urandom, 1'b0);
      if (v) n++;
      if (n == 255) begin
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL full_load_early_run: got %b want 0", cpu_run); end
      end
    end
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL full_load_run: got %b want 1", cpu_run); end
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        6:       a = IO;
        7:       a = CNT;
        8:       a = 32'h0000_0400 | ($urandom & 32'h0FFF_FFFC);
        9:       a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        default: a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      run_cycle(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), got);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w [4];
    logic [31:0] got;
    do_reset();
    load_cycle(1'b1, 32'hAAAA_0000, 1'b0);
    load_cycle(1'b1, 32'hBBBB_0001, 1'b0);
    do_reset();
    w = '{32'h0C0C_0C0C, 32'h0D0D_0D0D, 32'h0E0E_0E0E, 32'h0F0F_0F0F};
    for (int i = 0; i < 4; i++) load_cycle(1'b1, w[i], i == 3);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 32'(i * 4), '0, 1'b0, got);
      checks++; if (got !== w[i]) begin failures++; $display("FAIL reload_word%0d: got %h want %h", i, got, w[i]); end
    end
  endtask

  task automatic test_depth4();
    logic [31:0] w [6];
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    mem_write4 = 1'b0; addr4 = '0; write_data4 = '0;
    ld_valid4 = 1'b0; ld_data4 = '0; ld_last4 = 1'b0;
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    checks++; if ({cpu_run4, ld_ready4} !== 2'b01) begin failures++; $display("FAIL d4_reset: got %b want 01", {cpu_run4, ld_ready4}); end
    for (int i = 0; i < 6; i++) begin
      ld_valid4 = 1'b1; ld_data4 = w[i];
      checks++; if (ld_ready4 !== (i < 4)) begin failures++; $display("FAIL d4_ready%0d: got %b want %b", i, ld_ready4, i < 4); end
      step();
      checks++; if (cpu_run4 !== (i >= 3)) begin failures++; $display("FAIL d4_run%0d: got %b want %b", i, cpu_run4, i >= 3); end
    end
    ld_valid4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr4 = 32'(i * 4);
      step();
      exp = (i < 4) ? w[i] : 32'h0;
      checks++; if (read_data4 !== exp) begin failures++; $display("FAIL d4_read%0d: got %h want %h", i, read_data4, exp); end
    end
    checks++; if ({io_out4, misalign4} !== 33'd0) begin failures++; $display("FAIL d4_io_misalign: got %h want 0", {io_out4, misalign4}); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; reset4 = 1'b0;
    idle_inputs();
    mem_write4 = 1'b0; addr4 = '0; write_data4 = '0;
    ld_valid4 = 1'b0; ld_data4 = '0; ld_last4 = 1'b0;
    step();
    test_reset();
    test_program();
    test_random();
    test_reset_midload();
    test_depth4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
